// File: rtl/operand_feeder.sv
// Operand feeder: turns one BRAM word per read into skewed per-lane operands
// for an N-lane systolic array, then drains the skew and signals tile end.
module operand_feeder #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BRAM_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable_cu,
   input  logic [N*DATA_WIDTH-1:0] bram_data,
   output logic [N*DATA_WIDTH-1:0] lane_data,
   output logic [N-1:0]            lane_valid,
   output logic                    busy,
   output logic                    tile_done
);

   localparam int TILE_LEN = 1 << BRAM_DEPTH;
   localparam int CNT_W    = BRAM_DEPTH + 1;
   localparam int DCW      = (N > 2) ? $clog2(N - 1) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILE_LEN - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
   logic             cap_valid;

   // Next-state, vector count and drain count; decides when a word is captured
   always_comb begin
      state_d     = state_q;
      vec_cnt_d   = vec_cnt_q;
      drain_cnt_d = drain_cnt_q;
      rd_valid_d  = enable_cu;
      cap_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_cu) state_d = FILL;
         end
         FILL: begin
            if (rd_valid_q) begin
               cap_valid = 1'b1;
               if (vec_cnt_q == LAST_CNT) begin
                  vec_cnt_d   = '0;
                  drain_cnt_d = '0;
                  // With a single lane there is no skew left to drain
                  state_d     = (N == 1) ? DONE : DRAIN;
               end else begin
                  vec_cnt_d = vec_cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (int'(drain_cnt_q) == N - 2) begin
               drain_cnt_d = '0;
               state_d     = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rd_valid_q  <= 1'b0;
         vec_cnt_q   <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rd_valid_q  <= rd_valid_d;
         vec_cnt_q   <= vec_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign tile_done = (state_q == DONE);

   // Per-lane skew chains: lane i holds i+1 stages, the first loaded on capture.
   // Bubbles carry zero data so an invalid lane always reads as zero.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [i:0][DATA_WIDTH-1:0] dat_q, dat_d;
      logic [i:0]                 vld_q, vld_d;
      logic [DATA_WIDTH-1:0]      cap_elem;

      assign cap_elem = cap_valid ? bram_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

      if (i == 0) begin : g_first
         // Lane 0 is the single capture stage
         always_comb begin
            dat_d = cap_elem;
            vld_d = cap_valid;
         end
      end else begin : g_chain
         // Shift the chain by one stage and load the new element at the bottom
         always_comb begin
            dat_d = {dat_q[i-1:0], cap_elem};
            vld_d = {vld_q[i-1:0], cap_valid};
         end
      end

      // Skew registers with synchronous reset
      always_ff @(posedge clk) begin
         if (reset) begin
            dat_q <= '0;
            vld_q <= '0;
         end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
         end
      end

      assign lane_data[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
      assign lane_valid[i]                         = vld_q[i];
   end

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder (N=4, DATA_WIDTH=8, BRAM_DEPTH=2).
// Each row gives the inputs for one clock edge and the outputs expected just after it.
module tb_operand_feeder;

   localparam logic [31:0] V1 = 32'h04030201;
   localparam logic [31:0] V2 = 32'h14131211;
   localparam logic [31:0] V3 = 32'h24232221;
   localparam logic [31:0] V4 = 32'h34333231;
   localparam logic [31:0] J  = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable_cu;
   logic [31:0] bram_data;
   logic [31:0] lane_data;
   logic [3:0]  lane_valid;
   logic        busy;
   logic        tile_done;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic        rst;
      logic        en;
      logic [31:0] br;
      logic [31:0] data;
      logic [3:0]  valid;
      logic        busy;
      logic        done;
   } row_t;

   row_t rows[$];

   operand_feeder #(
      .N          (4),
      .DATA_WIDTH (8),
      .BRAM_DEPTH (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable_cu  (enable_cu),
      .bram_data  (bram_data),
      .lane_data  (lane_data),
      .lane_valid (lane_valid),
      .busy       (busy),
      .tile_done  (tile_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic add_row(input logic rst, input logic en, input logic [31:0] br,
                          input logic [31:0] data, input logic [3:0] valid,
                          input logic bsy, input logic done);
      row_t r;
      r.rst = rst; r.en = en; r.br = br; r.data = data;
      r.valid = valid; r.busy = bsy; r.done = done;
      rows.push_back(r);
   endtask

   // First nrows edges of a clean tile; hold keeps enable_cu high throughout
   task automatic push_tile(input logic hold, input int nrows);
      logic [31:0] br_t [9] = '{J, V1, V2, V3, V4, J, J, J, J};
      logic [31:0] dt_t [9] = '{32'h0, 32'h00000001, 32'h00000211, 32'h00031221,
                                32'h04132231, 32'h14233200, 32'h24330000,
                                32'h34000000, 32'h0};
      logic [3:0]  vl_t [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
      for (int k = 0; k < nrows; k++)
         add_row(1'b0, hold ? 1'b1 : (k < 4), br_t[k], dt_t[k], vl_t[k],
                 (k < 8), (k == 7));
   endtask

   task automatic run_rows(input string name);
      int k = 0;
      while (rows.size() > 0) begin
         row_t r = rows.pop_front();
         reset     = r.rst;
         enable_cu = r.en;
         bram_data = r.br;
         @(posedge clk);
         #1;
         check_eq($sformatf("%s[%0d].lane_data", name, k), lane_data, r.data);
         check_eq($sformatf("%s[%0d].lane_valid", name, k), {28'h0, lane_valid}, {28'h0, r.valid});
         check_eq($sformatf("%s[%0d].busy", name, k), {31'h0, busy}, {31'h0, r.busy});
         check_eq($sformatf("%s[%0d].tile_done", name, k), {31'h0, tile_done}, {31'h0, r.done});
         k++;
      end
      enable_cu = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      enable_cu = 1'b0;
      bram_data = J;

      // Reset state, with enable held high to show reset priority
      add_row(1'b1, 1'b1, J, 32'h0, 4'h0, 1'b0, 1'b0);
      add_row(1'b1, 1'b1, V1, 32'h0, 4'h0, 1'b0, 1'b0);
      run_rows("reset");

      // No enable for 20 cycles: stays idle and quiet
      for (int k = 0; k < 20; k++)
         add_row(1'b0, 1'b0, (k % 2 == 0) ? J : V3, 32'h0, 4'h0, 1'b0, 1'b0);
      run_rows("idle");

      // Basic tile, four consecutive reads
      push_tile(1'b0, 9);
      run_rows("tile");

      // One-cycle gap in enable between vectors 2 and 3
      add_row(1'b0, 1'b1, J,  32'h0,        4'h0, 1'b1, 1'b0);
      add_row(1'b0, 1'b1, V1, 32'h00000001, 4'h1, 1'b1, 1'b0);
      add_row(1'b0, 1'b0, V2, 32'h00000211, 4'h3, 1'b1, 1'b0);
      add_row(1'b0, 1'b1, J,  32'h00031200, 4'h6, 1'b1, 1'b0);
      add_row(1'b0, 1'b1, V3, 32'h04130021, 4'hD, 1'b1, 1'b0);
      add_row(1'b0, 1'b0, V4, 32'h14002231, 4'hB, 1'b1, 1'b0);
      add_row(1'b0, 1'b0, J,  32'h00233200, 4'h6, 1'b1, 1'b0);
      add_row(1'b0, 1'b0, J,  32'h24330000, 4'hC, 1'b1, 1'b0);
      add_row(1'b0, 1'b0, J,  32'h34000000, 4'h8, 1'b1, 1'b1);
      add_row(1'b0, 1'b0, J,  32'h0,        4'h0, 1'b0, 1'b0);
      run_rows("bubble");

      // Enable held through drain/done, then back-to-back second tile
      push_tile(1'b1, 9);
      push_tile(1'b0, 9);
      run_rows("held");

      // Reset during drain discards the tile; a new tile starts right after
      push_tile(1'b0, 6);
      add_row(1'b1, 1'b1, J, 32'h0, 4'h0, 1'b0, 1'b0);
      push_tile(1'b0, 9);
      run_rows("rst_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
